// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receiver and transmitter.
package rs232_pkg;

  localparam int unsigned DataBits = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Rounded clocks per bit.
  function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                               input int unsigned baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/rs232_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; same-cycle push and pop allowed even when full.
module rs232_fifo
  import rs232_pkg::*;
#(
  parameter int unsigned WIDTH = DataBits,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0] FullXor = {1'b1, {PtrW{1'b0}}};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rs232_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               do_push, do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = ((wr_ptr_q ^ rd_ptr_q) == FullXor);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[PtrW-1:0]];
  assign do_pop    = pop && !empty;
  // When full, a simultaneous pop frees the slot being written.
  assign do_push   = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
        wr_ptr_q                  <= wr_ptr_q + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/rs232_recv.sv
// 8N1 RS-232 receiver with mid-bit sampling, output FIFO, framing and overrun flags.
// Define RS232_RECV_FLOWCTL_EN to drive rs232_ctsn from FIFO occupancy.
module rs232_recv
  import rs232_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 133000000,
  parameter int unsigned BAUD_RATE  = 12000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rs232_txd,
  output logic                rs232_ctsn,
  output logic [DataBits-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                frame_error,
  output logic                overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW         = $clog2(DataBits);
  localparam int unsigned FifoPtrW     = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT);
  localparam logic [CntW-1:0] CntBit  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [IdxW-1:0] LastBit = IdxW'(DataBits - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("rs232_recv: CLKS_PER_BIT must be at least 4");
  end

  logic                rx_meta_q, rxs_q;
  rx_state_e           state_q;
  logic [CntW-1:0]     cnt_q;
  logic [IdxW-1:0]     bit_idx_q;
  logic [DataBits-1:0] shift_q;
  logic                frame_error_q, overrun_q;

  logic                push, pop;
  logic                fifo_empty, fifo_full;
  logic [FifoPtrW:0]   fifo_count;

  // Two-flop synchronizer; idle-high reset so a quiet line is not a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rs232_txd;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            cnt_q   <= CntHalf;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntOne;
          end else if (!rxs_q) begin
            cnt_q     <= CntBit;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            state_q <= StIdle;
          end
        end
        StData: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntOne;
          end else begin
            shift_q   <= {rxs_q, shift_q[DataBits-1:1]};
            cnt_q     <= CntBit;
            bit_idx_q <= bit_idx_q + IdxOne;
            if (bit_idx_q == LastBit) begin
              state_q <= StStop;
            end
          end
        end
        StStop: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntOne;
          end else if (rxs_q) begin
            state_q <= StIdle;
          end else begin
            frame_error_q <= 1'b1;
            state_q       <= StBreak;
          end
        end
        StBreak: begin
          // Hold here so a long low line reports only one framing error.
          if (rxs_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign push = (state_q == StStop) && (cnt_q == '0) && rxs_q;
  assign pop  = valid && ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && fifo_full && !pop;
    end
  end

  rs232_fifo #(
    .WIDTH (DataBits),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .head_data (data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign valid       = !fifo_empty;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

`ifdef RS232_RECV_FLOWCTL_EN
  // Throttle one entry early so a byte already on the wire still fits.
  localparam logic [FifoPtrW:0] CtsThresh = (FifoPtrW + 1)'(FIFO_DEPTH - 1);
  logic ctsn_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ctsn_q <= 1'b0;
    end else begin
      ctsn_q <= (fifo_count >= CtsThresh);
    end
  end

  assign rs232_ctsn = ctsn_q;
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
  assign rs232_ctsn        = 1'b0;
`endif

endmodule

// File: doc/rs232_recv.md
Name: rs232_recv

Overview:
- RS-232 receiver feeding the byte stream into the FPGA from the host TX line (rs232_txd).
- Sits directly upstream of the byte consumer and uses the same data/valid/ready handshake as the rs232_send3 transmitter, so the two can be looped back.
- Performs 8N1 framing with mid-bit sampling, buffers bytes in a small FIFO, and flags framing and overrun errors.

Parameters:
- CLOCK_FREQ, 133000000, system clock frequency in Hz.
- BAUD_RATE, 12000000, line rate in bit/s.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rs232_txd  input  1  asynchronous serial line from host; idles high.
- rs232_ctsn  output  1  clear-to-send toward host, active low.
- data  output  8  received byte at the FIFO head.
- valid  output  1  data holds a byte.
- ready  input  1  consumer accepts data.
- frame_error  output  1  one-cycle pulse when a stop bit samples low.
- overrun  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.

Behaviour:
- Localparams: CLKS_PER_BIT = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE, which is 11 at the defaults; HALF_BIT = CLKS_PER_BIT/2, which is 5. Elaboration error if CLKS_PER_BIT < 4.
- Input synchronizer:
  - 2 flops; both reset to 1.
  - The FSM sees rxs, delayed 2 cycles from the pin.
- Bit-timing counter: counts down from the loaded value and triggers the FSM action at 0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rxs==0, load HALF_BIT and go to START.
  - START: at count 0, if rxs==0, load CLKS_PER_BIT-1, clear the bit index, and go to DATA. If rxs==1 (glitch), return to IDLE with no error.
  - DATA: at each count 0, shift rxs into bit 7 of the shift register (LSB first) and reload. After the 8th bit, go to STOP.
  - STOP: at count 0:
    - If rxs==1: push the byte into the FIFO and go to IDLE.
    - If rxs==0: pulse frame_error, drop the byte, and go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. A held-low line yields exactly one frame_error.
- Latency: valid rises 1 cycle after the stop-bit sample cycle when the FIFO was empty.
- Handshake:
  - A transfer occurs on any cycle with valid && ready.
  - data and valid stay stable while valid && !ready.
  - valid never depends combinationally on ready.
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - Push and pop in the same cycle: both take effect, including when full. Full+pop+push is not an overrun.
  - Push while full without a pop: byte dropped, overrun pulses 1 cycle, FIFO contents unchanged.
- Reset (including mid-frame):
  - FSM to IDLE; FIFO emptied.
  - valid=0, data=8'h00.
  - frame_error=0, overrun=0.
  - rs232_ctsn=0.
  - A partially received frame is discarded.
  - After reset release, a line that is already low is treated as a start edge.

Optional Feature:
- Macro RS232_RECV_FLOWCTL_EN.
- Defined: rs232_ctsn is registered and driven to 1 when FIFO occupancy >= FIFO_DEPTH-1, otherwise 0. It deasserts one cycle after occupancy drops below that threshold. This leaves one slot of slack for a byte already in flight.
- Undefined: rs232_ctsn is tied to 0; overrun is the only back-pressure indication.

Decomposition:
- Shared package rs232_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - Function computing clocks-per-bit from CLOCK_FREQ and BAUD_RATE, shared with the transmitter.
  - Constant for data bit count (8).
- Sub-module rs232_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push/push_data, pop, head_data, empty, full, count.
  - Reused later in front of rs232_send3.

Test Plan:
- Default params, send 0xA5 at 11 clocks/bit, ready=1 -> one valid pulse with data=0xA5, 1 cycle after the stop sample; no errors.
- Back-to-back 0x00, 0xFF, 0x3C with ready=0 -> FIFO holds 3 bytes, valid=1. Then raise ready -> 0x00, 0xFF, 0x3C in order over 3 cycles, then valid=0.
- 5 bytes with ready=0 and FIFO_DEPTH=4 -> first 4 kept; overrun pulses once on the 5th stop bit. With RS232_RECV_FLOWCTL_EN, rs232_ctsn=1 after the 3rd byte is stored.
- Frame 0x55 with stop bit forced low, line then held low for 40 cycles -> frame_error pulses exactly once, no push. The next valid frame 0x81 is received correctly.
- 3-cycle low glitch on an idle line -> START rejects it; no valid, no error.
- Assert reset for 1 cycle midway through the data bits of 0x7E -> byte discarded, FIFO empty. A following 0x12 frame is received correctly.
